// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame-format codes and the
// oversampling default. Used by the transmit engine and by the receiver.
package uart_pkg;

    // Transmit state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    // Parity field codes; 2'b11 is reserved and behaves like none
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // DataBits field codes; anything without bit 2 set means 5 bits
    localparam logic [2:0] DB5 = 3'b100;
    localparam logic [2:0] DB6 = 3'b101;
    localparam logic [2:0] DB7 = 3'b110;
    localparam logic [2:0] DB8 = 3'b111;

    // Baud16Tick pulses per bit period
    localparam int OVERSAMPLE_DEFAULT = 16;

    // Index of the last data bit of a character (4 for 5 bits .. 7 for 8 bits)
    function automatic logic [2:0] last_data_index(input logic [2:0] data_bits);
        logic [2:0] idx;
        if (data_bits[2]) begin
            idx = 3'd4 + {1'b0, data_bits[1:0]};
        end else begin
            idx = 3'd4 + {1'b0, DB5[1:0]};
        end
        return idx;
    endfunction

    // Only odd and even produce a parity bit on the line
    function automatic logic parity_enabled(input logic [1:0] parity);
        return (parity == PAR_ODD) || (parity == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// UART transmit serializer. Pops a character from the TX FIFO and shifts
// it out on TXD as start, LSB-first data, optional parity and stop bits,
// with every bit lasting OVERSAMPLE Baud16Tick pulses.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_W     = 8
) (
    input  logic              DSP_CLK,
    input  logic              RESETn,
    input  logic              Baud16Tick,
    input  logic              UARTEn,
    input  logic              TxEn,
    input  logic [1:0]        Parity,
    input  logic              StopBits,
    input  logic [2:0]        DataBits,
    input  logic              TxFIFO_Empty,
    input  logic [DATA_W-1:0] TxFIFO_RData,
    output logic              TxFIFO_RdEn,
    output logic              TXD,
    output logic              TxBusy,
    output logic              TxDone
);

    localparam int              CNT_W    = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [CNT_W-1:0]  tick_cnt_q;
    logic [2:0]        bit_idx_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [1:0]        parity_lat_q;
    logic              stop_lat_q;
    logic [2:0]        last_idx_q;
    logic              parity_bit_q;
    logic              txd_q;
    logic              txd_d;
    logic              busy_q;
    logic              busy_d;
    logic              rd_en;
    logic              tx_done;

    logic              start_ok;
    logic              bit_end;
    logic              last_stop;
    logic [2:0]        load_last_idx;
    logic [DATA_W-1:0] load_mask;
    logic              parity_calc;

    assign start_ok      = UARTEn & TxEn & ~TxFIFO_Empty;
    assign bit_end       = Baud16Tick & (tick_cnt_q == CNT_LAST);
    assign last_stop     = (bit_idx_q == {2'b00, stop_lat_q});
    assign load_last_idx = last_data_index(DataBits);

    // Parity of the character being loaded, over the active data bits only
    always_comb begin
        load_mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i <= int'(load_last_idx)) begin
                load_mask[i] = 1'b1;
            end
        end
        if (Parity == PAR_ODD) begin
            parity_calc = ~^(TxFIFO_RData & load_mask);
        end else begin
            parity_calc = ^(TxFIFO_RData & load_mask);
        end
    end

    // State register
    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping UARTEn aborts the frame from any state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_ok) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_START;
            ST_START:  if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end && (bit_idx_q == last_idx_q)) begin
                    state_d = parity_enabled(parity_lat_q) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end && last_stop) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (!UARTEn) begin
            state_d = ST_IDLE;
        end
    end

    // Output decode: pop strobe, done pulse, next shift value and next line level
    always_comb begin
        rd_en   = (state_q == ST_IDLE) & start_ok;
        tx_done = (state_q == ST_STOP) & bit_end & last_stop & UARTEn;
        shift_d = shift_q;
        if (state_q == ST_LOAD) begin
            shift_d = TxFIFO_RData;
        end else if ((state_q == ST_DATA) && bit_end) begin
            shift_d = shift_q >> 1;
        end
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
            ST_PARITY: txd_d = parity_bit_q;
            default:   txd_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Registered line and busy outputs so TXD never glitches
    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn) begin
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
        end else begin
            txd_q  <= txd_d;
            busy_q <= busy_d;
        end
    end

    // Character shift register plus the frame format frozen at LOAD
    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn) begin
            shift_q      <= '0;
            parity_lat_q <= PAR_NONE;
            stop_lat_q   <= 1'b0;
            last_idx_q   <= 3'd0;
            parity_bit_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            if (state_q == ST_LOAD) begin
                parity_lat_q <= Parity;
                stop_lat_q   <= StopBits;
                last_idx_q   <= load_last_idx;
                parity_bit_q <= parity_calc;
            end
        end
    end

    // Oversample counter; restarts at LOAD so the start bit times from state entry
    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn) begin
            tick_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) || (state_q == ST_LOAD) || !UARTEn) begin
            tick_cnt_q <= '0;
        end else if (Baud16Tick) begin
            tick_cnt_q <= bit_end ? '0 : tick_cnt_q + 1'b1;
        end
    end

    // Bit counter for data and stop bits; zeroed on every state change
    always_ff @(posedge DSP_CLK or negedge RESETn) begin
        if (!RESETn) begin
            bit_idx_q <= 3'd0;
        end else if (state_q != state_d) begin
            bit_idx_q <= 3'd0;
        end else if (bit_end) begin
            bit_idx_q <= bit_idx_q + 3'd1;
        end
    end

    assign TxFIFO_RdEn = rd_en;
    assign TxDone      = tx_done;
    assign TXD         = txd_q;
    assign TxBusy      = busy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: a small FIFO model and a divided baud
// tick feed the engine, TXD is captured per cycle from the pop onward, and
// hand-computed frame images are compared against the capture.
module tb_uart_tx_engine;

    logic       DSP_CLK;
    logic       RESETn;
    logic       Baud16Tick;
    logic       UARTEn;
    logic       TxEn;
    logic [1:0] Parity;
    logic       StopBits;
    logic [2:0] DataBits;
    logic       TxFIFO_Empty;
    logic [7:0] TxFIFO_RData;
    logic       TxFIFO_RdEn;
    logic       TXD;
    logic       TxBusy;
    logic       TxDone;

    int check_count = 0;
    int err_count   = 0;
    int cyc         = 0;
    int tick_div    = 1;
    int wr_ptr      = 0;
    int rd_ptr      = 0;
    int pop_total   = 0;
    int done_total  = 0;

    logic [7:0] fifo_mem [0:15];
    logic       s_txd  [0:1023];
    logic       s_busy [0:1023];
    logic       s_done [0:1023];
    logic       s_rden [0:1023];

    uart_tx_engine #(.OVERSAMPLE(16), .DATA_W(8)) dut (
        .DSP_CLK      (DSP_CLK),
        .RESETn       (RESETn),
        .Baud16Tick   (Baud16Tick),
        .UARTEn       (UARTEn),
        .TxEn         (TxEn),
        .Parity       (Parity),
        .StopBits     (StopBits),
        .DataBits     (DataBits),
        .TxFIFO_Empty (TxFIFO_Empty),
        .TxFIFO_RData (TxFIFO_RData),
        .TxFIFO_RdEn  (TxFIFO_RdEn),
        .TXD          (TXD),
        .TxBusy       (TxBusy),
        .TxDone       (TxDone)
    );

    // 100 MHz system clock
    initial begin
        DSP_CLK = 1'b0;
        forever #5 DSP_CLK = ~DSP_CLK;
    end

    // Baud generator stand-in: one tick every tick_div cycles
    always @(posedge DSP_CLK) cyc <= cyc + 1;
    assign Baud16Tick = ((cyc % tick_div) == 0);

    // FIFO model: read data appears the cycle after the pop strobe
    assign TxFIFO_Empty = (wr_ptr == rd_ptr);
    always @(posedge DSP_CLK) begin
        if (TxFIFO_RdEn === 1'b1 && wr_ptr != rd_ptr) begin
            TxFIFO_RData <= fifo_mem[rd_ptr % 16];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    // Running totals of pops and completed frames
    always @(posedge DSP_CLK) begin
        if (TxFIFO_RdEn === 1'b1) pop_total <= pop_total + 1;
        if (TxDone === 1'b1) done_total <= done_total + 1;
    end

    // Hard stop if something hangs despite the bounded waits
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic syncCycle();
        @(posedge DSP_CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic uart_en, input logic tx_en, input logic [1:0] par,
                                 input logic stop, input logic [2:0] db);
        syncCycle();
        UARTEn   = uart_en;
        TxEn     = tx_en;
        Parity   = par;
        StopBits = stop;
        DataBits = db;
    endtask

    task automatic pushByte(input logic [7:0] b);
        fifo_mem[wr_ptr % 16] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic waitPop(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge DSP_CLK);
            if (TxFIFO_RdEn === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_pop_seen"}, 32'(found), 32'd1);
    endtask

    task automatic captureLine(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge DSP_CLK);
            s_txd[i]  = TXD;
            s_busy[i] = TxBusy;
            s_done[i] = TxDone;
            s_rden[i] = TxFIFO_RdEn;
        end
    endtask

    task automatic scanPulses(input bit use_done, input int lo, input int hi,
                              output int cnt, output int first);
        logic v;
        cnt   = 0;
        first = -1;
        for (int i = lo; i <= hi; i++) begin
            v = use_done ? s_done[i] : s_rden[i];
            if (v === 1'b1) begin
                if (first < 0) first = i;
                cnt++;
            end
        end
    endtask

    task automatic checkFrame(input string tag, input int base, input logic [15:0] exp_bits,
                              input int nbits);
        for (int k = 0; k < nbits; k++) begin
            checkOutput($sformatf("%s_bit%0d", tag, k), 32'(s_txd[base + 2 + 16 * k + 8]),
                        32'(exp_bits[k]));
        end
    endtask

    initial begin
        int cnt;
        int first;
        logic [7:0] b96;

        RESETn       = 1'b0;
        UARTEn       = 1'b0;
        TxEn         = 1'b0;
        Parity       = 2'b00;
        StopBits     = 1'b0;
        DataBits     = 3'b111;
        TxFIFO_RData = 8'h00;

        // Reset values
        repeat (3) @(negedge DSP_CLK);
        checkOutput("rst_txd", 32'(TXD), 32'd1);
        checkOutput("rst_busy", 32'(TxBusy), 32'd0);
        checkOutput("rst_done", 32'(TxDone), 32'd0);
        checkOutput("rst_rden", 32'(TxFIFO_RdEn), 32'd0);
        syncCycle();
        RESETn = 1'b1;

        // 1: 8N1 0xA5, tick every cycle
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 3'b111);
        syncCycle();
        pushByte(8'hA5);
        waitPop("t1");
        captureLine(200);
        checkOutput("t1_load_txd", 32'(s_txd[1]), 32'd1);
        checkOutput("t1_load_busy", 32'(s_busy[1]), 32'd1);
        checkOutput("t1_start_first", 32'(s_txd[2]), 32'd0);
        checkFrame("t1", 0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        scanPulses(1'b1, 0, 199, cnt, first);
        checkOutput("t1_done_cnt", 32'(cnt), 32'd1);
        checkOutput("t1_done_at", 32'(first), 32'd161);
        checkOutput("t1_busy_end", 32'(s_busy[162]), 32'd0);
        scanPulses(1'b0, 0, 199, cnt, first);
        checkOutput("t1_rden_cnt", 32'(cnt), 32'd1);

        // 2: 7E2 0x83, config scrambled mid-frame must not matter
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b1, 3'b110);
        syncCycle();
        pushByte(8'h83);
        waitPop("t2");
        fork
            captureLine(200);
            begin
                repeat (40) @(posedge DSP_CLK);
                #1;
                DataBits = 3'b111;
                Parity   = 2'b00;
                StopBits = 1'b0;
            end
        join
        checkFrame("t2", 0, {5'b0, 2'b11, 1'b0, 7'h03, 1'b0}, 11);
        scanPulses(1'b1, 0, 199, cnt, first);
        checkOutput("t2_done_at", 32'(first), 32'd177);
        checkOutput("t2_stop2_busy", 32'(s_busy[170]), 32'd1);

        // 3: 5O1 0x00, odd parity of zeros is 1
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 3'b100);
        syncCycle();
        pushByte(8'h00);
        waitPop("t3");
        captureLine(200);
        checkFrame("t3", 0, {8'b0, 8'b1100_0000}, 8);
        scanPulses(1'b1, 0, 199, cnt, first);
        checkOutput("t3_done_at", 32'(first), 32'd129);

        // 4: three back-to-back 8N1 frames
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 3'b111);
        syncCycle();
        pushByte(8'h11);
        pushByte(8'h22);
        pushByte(8'h33);
        waitPop("t4");
        captureLine(520);
        scanPulses(1'b0, 0, 519, cnt, first);
        checkOutput("t4_rden_cnt", 32'(cnt), 32'd3);
        checkOutput("t4_rden2", 32'(s_rden[162]), 32'd1);
        checkOutput("t4_rden3", 32'(s_rden[324]), 32'd1);
        scanPulses(1'b1, 0, 519, cnt, first);
        checkOutput("t4_done_cnt", 32'(cnt), 32'd3);
        checkOutput("t4_done1", 32'(s_done[161]), 32'd1);
        checkOutput("t4_done3", 32'(s_done[485]), 32'd1);
        checkOutput("t4_gap_start", 32'(s_txd[164]), 32'd0);
        checkFrame("t4a", 0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
        checkFrame("t4b", 162, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
        checkFrame("t4c", 324, {6'b0, 1'b1, 8'h33, 1'b0}, 10);
        checkOutput("t4_idle_txd", 32'(s_txd[487]), 32'd1);
        checkOutput("t4_idle_busy", 32'(s_busy[486]), 32'd0);

        // 5: UARTEn drop in data bit 3, then re-enable
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 3'b111);
        syncCycle();
        pushByte(8'h00);
        pushByte(8'h3C);
        waitPop("t5");
        fork
            captureLine(260);
            begin
                repeat (70) @(posedge DSP_CLK);
                #1;
                UARTEn = 1'b0;
                repeat (10) @(posedge DSP_CLK);
                #1;
                UARTEn = 1'b1;
            end
        join
        checkOutput("t5_pre_busy", 32'(s_busy[70]), 32'd1);
        checkOutput("t5_abort_txd", 32'(s_txd[71]), 32'd1);
        checkOutput("t5_abort_busy", 32'(s_busy[71]), 32'd0);
        scanPulses(1'b0, 1, 79, cnt, first);
        checkOutput("t5_no_pop_off", 32'(cnt), 32'd0);
        checkOutput("t5_repop", 32'(s_rden[80]), 32'd1);
        scanPulses(1'b1, 0, 259, cnt, first);
        checkOutput("t5_done_cnt", 32'(cnt), 32'd1);
        checkOutput("t5_done_at", 32'(first), 32'd241);
        checkFrame("t5", 80, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);

        // 6a: tick every 4th cycle, TxEn dropped during START
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 3'b111);
        tick_div = 4;
        do syncCycle(); while ((cyc % 4) != 0);
        pushByte(8'h96);
        pushByte(8'h42);
        waitPop("t6");
        fork
            captureLine(700);
            begin
                repeat (10) @(posedge DSP_CLK);
                #1;
                TxEn = 1'b0;
            end
        join
        b96 = 8'h96;
        checkOutput("t6_start", 32'(s_txd[33]), 32'd0);
        checkOutput("t6_start_end", 32'(s_txd[64]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("t6_bit%0d", k), 32'(s_txd[97 + 64 * k]), 32'(b96[k]));
        end
        checkOutput("t6_stop", 32'(s_txd[609]), 32'd1);
        scanPulses(1'b1, 0, 699, cnt, first);
        checkOutput("t6_done_at", 32'(first), 32'd640);
        checkOutput("t6_idle_busy", 32'(s_busy[641]), 32'd0);
        scanPulses(1'b0, 1, 699, cnt, first);
        checkOutput("t6_no_more_pop", 32'(cnt), 32'd0);

        // 6b: asynchronous reset in the stop bit of the next frame
        syncCycle();
        tick_div = 1;
        TxEn     = 1'b1;
        waitPop("t6b");
        repeat (150) @(posedge DSP_CLK);
        #1;
        checkOutput("t6b_stop_busy", 32'(TxBusy), 32'd1);
        checkOutput("t6b_stop_txd", 32'(TXD), 32'd1);
        RESETn = 1'b0;
        #1;
        checkOutput("t6b_rst_txd", 32'(TXD), 32'd1);
        checkOutput("t6b_rst_busy", 32'(TxBusy), 32'd0);
        checkOutput("t6b_rst_done", 32'(TxDone), 32'd0);
        repeat (3) @(posedge DSP_CLK);
        #3;
        RESETn = 1'b1;
        repeat (20) @(negedge DSP_CLK);
        checkOutput("t6b_after_busy", 32'(TxBusy), 32'd0);
        checkOutput("pop_total", 32'(pop_total), 32'd10);
        checkOutput("done_total", 32'(done_total), 32'd8);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
